// File: rtl/sobel_scan_ctrl.sv
// Raster-scan sequencer for the Sobel front end: issues one pixel read per
// ready cycle, shifts returned pixels into the window, and tags interior windows.
module sobel_scan_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              shift_en,
  output logic              win_valid,
  output logic [CNT_W-1:0]  win_x,
  output logic [CNT_W-1:0]  win_y,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] EDGE   = CNT_W'(2);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd;

  // vld_pipe_q[1] = shift stage, vld_pipe_q[2] = window-updated stage
  logic [2:1]          vld_pipe_q;
  logic [CNT_W-1:0]    px_q, py_q;
  logic [CNT_W-1:0]    win_x_q, win_y_q;
  logic                interior;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    rd      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      S_FETCH: begin
        rd = out_ready;
        if (rd) begin
          // Linear address tracks the raster position, so no y*IMG_W product.
          addr_d = addr_q + ADDR_W'(1);
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) state_d = S_DRAIN;
            else               y_d = y_q + CNT_W'(1);
          end else begin
            x_d = x_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign interior = vld_pipe_q[1] && (px_q >= EDGE) && (py_q >= EDGE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      px_q       <= '0;
      py_q       <= '0;
      win_x_q    <= '0;
      win_y_q    <= '0;
    end else begin
      vld_pipe_q[1] <= rd;
      vld_pipe_q[2] <= interior;
      px_q          <= x_q;
      py_q          <= y_q;
      // The newest pixel is the window's bottom-right corner; centre is one up-left.
      if (interior) begin
        win_x_q <= px_q - CNT_W'(1);
        win_y_q <= py_q - CNT_W'(1);
      end
    end
  end

  assign pix_rd_en = rd;
  assign pix_addr  = addr_q;
  assign shift_en  = vld_pipe_q[1];
  assign win_valid = vld_pipe_q[2];
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Bench for sobel_scan_ctrl on an 8x6 image: timestamp-based event model
// compared every cycle, plus hand-computed expectations per scenario.
module tb_sobel_scan_ctrl;
  localparam int W = 8, H = 6, AW = 6, CW = 3;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic          pix_rd_en, shift_en, win_valid, busy, done;
  logic [AW-1:0] pix_addr;
  logic [CW-1:0] win_x, win_y;

  sobel_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
    .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .shift_en(shift_en),
    .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Model: reads are timestamped; shift, window and done are scheduled
  // as future events keyed by cycle number.
  bit m_idle = 1'b1, m_scan = 1'b0;
  int m_n = 0, m_drain = -1, m_done = -1;
  bit ex_sh[int];
  int ex_wx[int], ex_wy[int];

  // Per-scenario log of observed DUT behaviour, indexed relative to start cycle.
  int s_cyc = -1000;
  int rd_k[$], sh_k[$], win_k[$], wx_l[$], wy_l[$], done_k[$];
  int o_rd[0:127], o_sh[0:127], o_win[0:127], o_busy[0:127];
  int o_done[0:127], o_addr[0:127], o_wx[0:127], o_wy[0:127];

  always @(negedge clk) begin
    int  k;
    bit  e_rd, e_win;
    if (cyc >= 1) begin
      e_rd  = m_scan && out_ready;
      e_win = ex_wx.exists(cyc);
      chk("pix_rd_en", int'(pix_rd_en), int'(e_rd));
      if (m_scan) chk("pix_addr", int'(pix_addr), m_n);
      chk("shift_en", int'(shift_en), int'(ex_sh.exists(cyc)));
      chk("win_valid", int'(win_valid), int'(e_win));
      if (e_win && win_valid) begin
        chk("win_x", int'(win_x), ex_wx[cyc]);
        chk("win_y", int'(win_y), ex_wy[cyc]);
      end
      chk("busy", int'(busy), int'(m_scan || cyc == m_drain));
      chk("done", int'(done), int'(cyc == m_done));

      k = cyc - s_cyc;
      if (k >= 0 && k < 128) begin
        o_rd[k] = int'(pix_rd_en);  o_sh[k] = int'(shift_en);
        o_win[k] = int'(win_valid); o_busy[k] = int'(busy);
        o_done[k] = int'(done);     o_addr[k] = int'(pix_addr);
        o_wx[k] = int'(win_x);      o_wy[k] = int'(win_y);
        if (pix_rd_en) rd_k.push_back(k);
        if (shift_en)  sh_k.push_back(k);
        if (win_valid) begin win_k.push_back(k); wx_l.push_back(int'(win_x)); wy_l.push_back(int'(win_y)); end
        if (done)      done_k.push_back(k);
      end

      if (!rst) begin
        m_idle = 1'b1; m_scan = 1'b0; m_drain = -1; m_done = -1;
        ex_sh.delete(); ex_wx.delete(); ex_wy.delete();
      end else begin
        if (m_idle && start) begin
          m_idle = 1'b0; m_scan = 1'b1; m_n = 0;
        end else if (e_rd) begin
          ex_sh[cyc+1] = 1'b1;
          if (m_n % W >= 2 && m_n / W >= 2) begin
            ex_wx[cyc+2] = m_n % W - 1;
            ex_wy[cyc+2] = m_n / W - 1;
          end
          m_n++;
          if (m_n == W*H) begin
            m_scan = 1'b0; m_drain = cyc + 1; m_done = cyc + 2;
          end
        end
        if (cyc == m_done) m_idle = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int sc, input int k);
    rst = 1'b1; out_ready = 1'b1; start = 1'b0;
    case (sc)
      1, 3: start = (k == 0);
      2: begin start = (k == 0); out_ready = !(k >= 10 && k <= 14); end
      4: start = (k == 0 || k == 5 || k == 30);
      5: begin start = (k == 0); rst = (k != 20); end
      6: start = (k < 60);
      default: ;
    endcase
  endtask

  task automatic run(input int sc, input int len);
    s_cyc = -1000;
    rd_k.delete(); sh_k.delete(); win_k.delete();
    wx_l.delete(); wy_l.delete(); done_k.delete();
    tick();
    s_cyc = cyc;
    for (int k = 0; k < len; k++) begin
      drive(sc, k);
      tick();
    end
    start = 1'b0; out_ready = 1'b1; rst = 1'b1;
  endtask

  // Interior centres of an 8x6 frame in raster order: x 1..6, y 1..4.
  task automatic chk_coords(input int first, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      chk("coord_x", wx_l[first+i], 1 + i % 6);
      chk("coord_y", wy_l[first+i], 1 + i / 6);
    end
  endtask

  initial begin
    int nb;
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_addr", int'(pix_addr), 0);
    rst = 1'b1;
    tick();

    // plain frame
    run(1, 70);
    chk("s1_reads", rd_k.size(), 48);
    chk("s1_first_rd", rd_k[0], 1);
    chk("s1_last_rd", rd_k[47], 48);
    chk("s1_addr_first", o_addr[1], 0);
    chk("s1_addr_last", o_addr[48], 47);
    chk("s1_wrap_a7", o_addr[8], 7);
    chk("s1_wrap_a8", o_addr[9], 8);
    chk("s1_first_sh", sh_k[0], 2);
    chk("s1_last_sh", sh_k[sh_k.size()-1], 49);
    chk("s1_wins", win_k.size(), 24);
    chk("s1_first_win", win_k[0], 21);
    chk("s1_last_win", win_k[23], 50);
    chk("s1_last_wx", wx_l[23], 6);
    chk("s1_last_wy", wy_l[23], 4);
    chk("s1_dones", done_k.size(), 1);
    chk("s1_done_k", done_k[0], 50);
    chk("s1_busy49", o_busy[49], 1);
    chk("s1_busy50", o_busy[50], 0);
    if (win_k.size() == 24) chk_coords(0, 24);

    // stall cycles 10..14
    run(2, 75);
    chk("s2_wins", win_k.size(), 24);
    chk("s2_done_k", done_k[0], 55);
    for (int k = 10; k <= 14; k++) begin
      chk("s2_stall_addr", o_addr[k], 9);
      chk("s2_stall_rd", o_rd[k], 0);
    end
    if (win_k.size() == 24) chk_coords(0, 24);

    // start re-asserted during the scan
    run(4, 70);
    chk("s4_dones", done_k.size(), 1);
    chk("s4_done_k", done_k[0], 50);
    nb = 0;
    for (int k = 1; k <= 49; k++) nb += o_busy[k];
    chk("s4_busy_cnt", nb, 49);

    // reset mid-frame
    run(5, 40);
    chk("s5_rd", o_rd[21], 0);
    chk("s5_sh", o_sh[21], 0);
    chk("s5_win", o_win[21], 0);
    chk("s5_busy", o_busy[21], 0);
    chk("s5_done", o_done[21], 0);
    chk("s5_addr", o_addr[21], 0);
    chk("s5_wx", o_wx[21], 0);
    chk("s5_wy", o_wy[21], 0);
    chk("s5_dones", done_k.size(), 0);

    // rescan after reset
    run(3, 70);
    chk("s3_first_rd", rd_k[0], 1);
    chk("s3_first_addr", o_addr[1], 0);
    chk("s3_wins", win_k.size(), 24);
    chk("s3_dones", done_k.size(), 1);

    // back-to-back with start held high
    run(6, 115);
    chk("s6_dones", done_k.size(), 2);
    chk("s6_done0", done_k[0], 50);
    if (done_k.size() == 2) chk("s6_done1", done_k[1], 101);
    chk("s6_wins", win_k.size(), 48);
    chk("s6_reads", rd_k.size(), 96);
    if (rd_k.size() > 48) chk("s6_f2_first_rd", rd_k[48], 52);
    if (win_k.size() == 48) begin chk_coords(0, 24); chk_coords(24, 24); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
